fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory address, and produces the IF/ID pipeline register consumed by decode. It applies stall, flush and branch/jump redirect requests from the hazard unit and ID-stage branch logic. It also keeps three performance counters that the simulation bench prints alongside register contents.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage; PC register, imem address,
// IF/ID pipeline register, redirect/stall/flush handling, perf counters.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   stall, flush          hazard-unit hold / bubble requests
//   branch_taken/_target  ID-stage taken branch and its destination
//   jump/jump_target      ID-stage j/jal and its destination
//   imem_addr, imem_data  combinational instruction-memory read port
//   pc                    current PC register
//   if_id_instr/_pc_plus4/_valid  IF/ID register (valid 0 = bubble)
//   fetch_count, stall_count, flush_count  performance counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            pc,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE =
        {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_MAX = '1;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [FLUSH_CNT_W-1:0] flush_next;

    assign redirect   = branch_taken | jump;
    // Branch wins when both branch and jump resolve in the same cycle.
    assign target_raw = branch_taken ? branch_target : jump_target;
    assign target     = {target_raw[31:2], 2'b00};
    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;

    // Bubble counter saturates rather than wrapping.
    assign flush_next = (flush_count == FLUSH_MAX) ?
                        flush_count : flush_count + FLUSH_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            fetch_count    <= 32'd0;
            stall_count    <= 32'd0;
            flush_count    <= '0;
        end else if (redirect) begin
            // Word fetched this cycle is on the wrong path: drop it.
            pc             <= target;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            flush_count    <= flush_next;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
            // PC holds, but a concurrent flush still bubbles IF/ID.
            if (flush) begin
                if_id_instr    <= 32'd0;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
                flush_count    <= flush_next;
            end
        end else if (flush) begin
            pc             <= pc_plus4;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            flush_count    <= flush_next;
        end else begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_data;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; two instances, one
// at the default reset PC and one at 0xFFFF_FFFC to cover pc wrap.
module tb_fetch_stage;

    typedef struct {
        int          id;
        bit          sel;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [15:0] fl;
    } exp_t;

    logic        clock = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  stl = 2'b00;
    logic [1:0]  fls = 2'b00;
    logic [1:0]  btk = 2'b00;
    logic [1:0]  jmp = 2'b00;
    logic [31:0] btg [2];
    logic [31:0] jtg [2];
    logic [31:0] iaddr [2];
    logic [31:0] idata [2];
    logic [31:0] pcv [2];
    logic [31:0] ins [2];
    logic [31:0] p4 [2];
    logic [1:0]  vld;
    logic [31:0] fcn [2];
    logic [31:0] scn [2];
    logic [15:0] fln [2];

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   vid = 0;

    always #5 clock = ~clock;

    // Memory model: word at address A is A | 0x2000_0000.
    assign idata[0] = iaddr[0] | 32'h2000_0000;
    assign idata[1] = iaddr[1] | 32'h2000_0000;

    fetch_stage dut0 (
        .clock(clock), .reset(rst[0]), .stall(stl[0]), .flush(fls[0]),
        .branch_taken(btk[0]), .branch_target(btg[0]),
        .jump(jmp[0]), .jump_target(jtg[0]),
        .imem_addr(iaddr[0]), .imem_data(idata[0]), .pc(pcv[0]),
        .if_id_instr(ins[0]), .if_id_pc_plus4(p4[0]),
        .if_id_valid(vld[0]), .fetch_count(fcn[0]),
        .stall_count(scn[0]), .flush_count(fln[0])
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FLUSH_CNT_W(16)) dut1 (
        .clock(clock), .reset(rst[1]), .stall(stl[1]), .flush(fls[1]),
        .branch_taken(btk[1]), .branch_target(btg[1]),
        .jump(jmp[1]), .jump_target(jtg[1]),
        .imem_addr(iaddr[1]), .imem_data(idata[1]), .pc(pcv[1]),
        .if_id_instr(ins[1]), .if_id_pc_plus4(p4[1]),
        .if_id_valid(vld[1]), .fetch_count(fcn[1]),
        .stall_count(scn[1]), .flush_count(fln[1])
    );

    // Monitor: each expectation describes state after the next edge.
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (pcv[e.sel] !== e.pc || iaddr[e.sel] !== e.pc ||
                ins[e.sel] !== e.instr || p4[e.sel] !== e.pc4 ||
                vld[e.sel] !== e.v || fcn[e.sel] !== e.fc ||
                scn[e.sel] !== e.sc || fln[e.sel] !== e.fl) begin
                n_err++;
                $display({"FAIL vec%0d dut%0d: got pc=%h addr=%h ",
                          "instr=%h pc4=%h v=%b fc=%0d sc=%0d fl=%h; ",
                          "want pc=%h instr=%h pc4=%h v=%b fc=%0d ",
                          "sc=%0d fl=%h"},
                         e.id, e.sel, pcv[e.sel], iaddr[e.sel],
                         ins[e.sel], p4[e.sel], vld[e.sel], fcn[e.sel],
                         scn[e.sel], fln[e.sel], e.pc, e.instr, e.pc4,
                         e.v, e.fc, e.sc, e.fl);
            end
        end
    end

    task automatic cyc(
        input bit s, input logic r, input logic st, input logic fl,
        input logic bt, input logic [31:0] bg,
        input logic jp, input logic [31:0] jg,
        input logic [31:0] epc, input logic [31:0] ei,
        input logic [31:0] ep4, input logic ev,
        input logic [31:0] efc, input logic [31:0] esc,
        input logic [15:0] efl);
        exp_t x;
        @(posedge clock);
        #2;
        rst[s] = r;
        stl[s] = st;
        fls[s] = fl;
        btk[s] = bt;
        btg[s] = bg;
        jmp[s] = jp;
        jtg[s] = jg;
        x.id = vid; x.sel = s; x.pc = epc; x.instr = ei; x.pc4 = ep4;
        x.v = ev; x.fc = efc; x.sc = esc; x.fl = efl;
        vid++;
        q.push_back(x);
    endtask

    initial begin
        btg[0] = 0; btg[1] = 0; jtg[0] = 0; jtg[1] = 0;

        // Instance with RESET_PC = 0xFFFF_FFFC: wrap and reset mid-stall.
        cyc(1, 1,0,0, 0,0, 0,0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        cyc(1, 0,0,0, 0,0, 0,0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 1, 0, 0);
        cyc(1, 0,1,0, 0,0, 0,0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 1, 1, 0);
        cyc(1, 1,1,0, 0,0, 0,0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);

        // Default instance.
        cyc(0, 1,0,0, 0,0, 0,0, 32'h0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0,0,0, 0,0, 0,0, 32'h4, 32'h2000_0000, 32'h4, 1, 1, 0, 0);
        cyc(0, 0,0,0, 0,0, 0,0, 32'h8, 32'h2000_0004, 32'h8, 1, 2, 0, 0);
        cyc(0, 0,1,0, 0,0, 0,0, 32'h8, 32'h2000_0004, 32'h8, 1, 2, 1, 0);
        cyc(0, 0,1,0, 0,0, 0,0, 32'h8, 32'h2000_0004, 32'h8, 1, 2, 2, 0);
        cyc(0, 0,0,0, 0,0, 0,0, 32'hC, 32'h2000_0008, 32'hC, 1, 3, 2, 0);
        cyc(0, 0,0,0, 1,32'h43, 0,0, 32'h40, 0, 0, 0, 3, 2, 1);
        cyc(0, 0,0,0, 0,0, 0,0, 32'h44, 32'h2000_0040, 32'h44, 1, 4, 2, 1);
        cyc(0, 0,1,0, 1,32'h100, 1,32'h200, 32'h100, 0, 0, 0, 4, 2, 2);
        cyc(0, 0,0,0, 0,0, 0,0,
            32'h104, 32'h2000_0100, 32'h104, 1, 5, 2, 2);
        cyc(0, 0,0,0, 0,0, 1,32'h203, 32'h200, 0, 0, 0, 5, 2, 3);
        cyc(0, 0,0,0, 0,0, 0,0,
            32'h204, 32'h2000_0200, 32'h204, 1, 6, 2, 3);
        cyc(0, 0,1,1, 0,0, 0,0, 32'h204, 0, 0, 0, 6, 3, 4);
        cyc(0, 0,0,1, 0,0, 0,0, 32'h208, 0, 0, 0, 6, 3, 5);
        cyc(0, 0,0,0, 0,0, 0,0,
            32'h20C, 32'h2000_0208, 32'h20C, 1, 7, 3, 5);
        cyc(0, 1,1,0, 0,0, 0,0, 32'h0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0,0,0, 0,0, 0,0, 32'h4, 32'h2000_0000, 32'h4, 1, 1, 0, 0);

        // Long flush run: counter saturates, pc keeps advancing.
        cyc(0, 1,0,0, 0,0, 0,0, 32'h0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 32'h1_0005; k++) begin
            cyc(0, 0,0,1, 0,0, 0,0, 32'(k * 4), 0, 0, 0, 0, 0,
                (k > 32'hFFFF) ? 16'hFFFF : k[15:0]);
        end
        cyc(0, 0,0,0, 0,0, 0,0,
            32'h4_0018, 32'h2004_0014, 32'h4_0018, 1, 1, 0, 16'hFFFF);

        @(posedge clock);
        #3;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
